decode_stage: RTL and testbench

Decode stage between instruction fetch/register-file read and the execute stage. It decodes one RV32I instruction per cycle into the execute-stage operation code (`exe_fun`), operands (`op1_data`/`op2_data`) and control bits. The ALU consumes these directly. Outputs are registered and use a valid/ready handshake, with an optional skid buffer so `id_ready` never depends combinationally on `ex_ready`.

---
 rtl/decode_stage_pkg.sv | 86 ++++++++
 rtl/decode_stage_imm_gen.sv | 17 +
 rtl/decode_stage.sv | 240 ++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Core constants: execute-stage operation codes, RV32I opcode/funct fields and
// the decoded payload carried from decode to execute.
package decode_stage_pkg;

  typedef enum logic [4:0] {
    ALU_X     = 5'd0,
    ALU_ADD   = 5'd1,
    ALU_SUB   = 5'd2,
    ALU_SLL   = 5'd3,
    ALU_SLT   = 5'd4,
    ALU_SLTU  = 5'd5,
    ALU_XOR   = 5'd6,
    ALU_SRL   = 5'd7,
    ALU_SRA   = 5'd8,
    ALU_OR    = 5'd9,
    ALU_AND   = 5'd10,
    ALU_JALR  = 5'd11,
    ALU_COPY1 = 5'd12,
    BR_BEQ    = 5'd13,
    BR_BNE    = 5'd14,
    BR_BLT    = 5'd15,
    BR_BGE    = 5'd16,
    BR_BLTU   = 5'd17,
    BR_BGEU   = 5'd18
  } exe_fun_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    exe_fun_e    exe_fun;
    logic [31:0] op1_data;
    logic [31:0] op2_data;
    logic        is_branch;
    logic        is_jump;
    logic [31:0] br_target;
    logic        wb_en;
    logic [4:0]  rd_addr;
    logic [31:0] pc;
    logic        illegal;
  } dec_payload_t;

  // Register/immediate ALU op from funct3; alt selects SUB/SRA.
  function automatic exe_fun_e f3_to_alu(input logic [2:0] f3, input logic alt);
    exe_fun_e fun;
    case (f3)
      F3_ADD_SUB: fun = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     fun = ALU_SLL;
      F3_SLT:     fun = ALU_SLT;
      F3_SLTU:    fun = ALU_SLTU;
      F3_XOR:     fun = ALU_XOR;
      F3_SRL_SRA: fun = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      fun = ALU_OR;
      F3_AND:     fun = ALU_AND;
      default:    fun = ALU_X;
    endcase
    return fun;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: sign-extended I/S/B/U/J immediates of an RV32I word.
module imm_gen (
  input  logic [31:0] inst_i,
  output logic [31:0] imm_i_o,
  output logic [31:0] imm_s_o,
  output logic [31:0] imm_b_o,
  output logic [31:0] imm_u_o,
  output logic [31:0] imm_j_o
);

  assign imm_i_o = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u_o = {inst_i[31:12], 12'h000};
  assign imm_j_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes one instruction per cycle into a registered
// execute payload behind a valid/ready handshake with optional skid buffer.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter bit ENABLE_SKID = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_inst,
  input  logic [31:0] id_pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [4:0]  ex_exe_fun,
  output logic [31:0] ex_op1_data,
  output logic [31:0] ex_op2_data,
  output logic        ex_is_branch,
  output logic        ex_is_jump,
  output logic [31:0] ex_br_target,
  output logic        ex_wb_en,
  output logic [4:0]  ex_rd_addr,
  output logic [31:0] ex_pc,
  output logic        ex_illegal
);

  logic [6:0]   opcode_s;
  logic [2:0]   funct3_s;
  logic [6:0]   funct7_s;
  logic [4:0]   rd_s;
  logic [31:0]  imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic         wb_s;
  logic         accept_s;
  dec_payload_t decoded_s;
  dec_payload_t out_q, out_d, skid_q, skid_d;
  logic         out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;

  assign opcode_s = id_inst[6:0];
  assign funct3_s = id_inst[14:12];
  assign funct7_s = id_inst[31:25];
  assign rd_s     = id_inst[11:7];
  assign rs1_addr = id_inst[19:15];
  assign rs2_addr = id_inst[24:20];

  imm_gen u_imm_gen (
    .inst_i  (id_inst),
    .imm_i_o (imm_i_s),
    .imm_s_o (imm_s_s),
    .imm_b_o (imm_b_s),
    .imm_u_o (imm_u_s),
    .imm_j_o (imm_j_s)
  );

  // Instruction decode into the execute payload; unknown encodings flow as illegal.
  always_comb begin
    decoded_s         = '0;
    decoded_s.exe_fun = ALU_X;
    decoded_s.rd_addr = rd_s;
    decoded_s.pc      = id_pc;
    wb_s              = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        if ((funct7_s == F7_BASE) ||
            ((funct7_s == F7_ALT) && ((funct3_s == F3_ADD_SUB) || (funct3_s == F3_SRL_SRA)))) begin
          decoded_s.exe_fun  = f3_to_alu(funct3_s, funct7_s[5]);
          decoded_s.op1_data = rs1_data;
          decoded_s.op2_data = rs2_data;
          wb_s               = 1'b1;
        end else begin
          decoded_s.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        if (((funct3_s == F3_SLL) && (funct7_s != F7_BASE)) ||
            ((funct3_s == F3_SRL_SRA) && (funct7_s != F7_BASE) && (funct7_s != F7_ALT))) begin
          decoded_s.illegal = 1'b1;
        end else if ((funct3_s == F3_SLL) || (funct3_s == F3_SRL_SRA)) begin
          decoded_s.exe_fun  = f3_to_alu(funct3_s, funct7_s[5]);
          decoded_s.op1_data = rs1_data;
          decoded_s.op2_data = {27'd0, id_inst[24:20]};
          wb_s               = 1'b1;
        end else begin
          decoded_s.exe_fun  = f3_to_alu(funct3_s, 1'b0);
          decoded_s.op1_data = rs1_data;
          decoded_s.op2_data = imm_i_s;
          wb_s               = 1'b1;
        end
      end
      OPC_LUI: begin
        decoded_s.exe_fun  = ALU_COPY1;
        decoded_s.op1_data = imm_u_s;
        wb_s               = 1'b1;
      end
      OPC_AUIPC: begin
        decoded_s.exe_fun  = ALU_ADD;
        decoded_s.op1_data = id_pc;
        decoded_s.op2_data = imm_u_s;
        wb_s               = 1'b1;
      end
      OPC_JAL: begin
        decoded_s.exe_fun   = ALU_ADD;
        decoded_s.op1_data  = id_pc;
        decoded_s.op2_data  = 32'd4;
        decoded_s.is_jump   = 1'b1;
        decoded_s.br_target = id_pc + imm_j_s;
        wb_s                = 1'b1;
      end
      OPC_JALR: begin
        if (funct3_s == 3'b000) begin
          decoded_s.exe_fun  = ALU_JALR;
          decoded_s.op1_data = rs1_data;
          decoded_s.op2_data = imm_i_s;
          decoded_s.is_jump  = 1'b1;
          wb_s               = 1'b1;
        end else begin
          decoded_s.illegal = 1'b1;
        end
      end
      OPC_BRANCH: begin
        case (funct3_s)
          F3_BEQ:  decoded_s.exe_fun = BR_BEQ;
          F3_BNE:  decoded_s.exe_fun = BR_BNE;
          F3_BLT:  decoded_s.exe_fun = BR_BLT;
          F3_BGE:  decoded_s.exe_fun = BR_BGE;
          F3_BLTU: decoded_s.exe_fun = BR_BLTU;
          F3_BGEU: decoded_s.exe_fun = BR_BGEU;
          default: decoded_s.illegal = 1'b1;
        endcase
        if (!decoded_s.illegal) begin
          decoded_s.op1_data  = rs1_data;
          decoded_s.op2_data  = rs2_data;
          decoded_s.is_branch = 1'b1;
          decoded_s.br_target = id_pc + imm_b_s;
        end else begin
          decoded_s.is_branch = 1'b0;
        end
      end
      OPC_LOAD: begin
        if ((funct3_s == 3'b011) || (funct3_s == 3'b110) || (funct3_s == 3'b111)) begin
          decoded_s.illegal = 1'b1;
        end else begin
          decoded_s.exe_fun  = ALU_ADD;
          decoded_s.op1_data = rs1_data;
          decoded_s.op2_data = imm_i_s;
          wb_s               = 1'b1;
        end
      end
      OPC_STORE: begin
        if ((funct3_s == 3'b000) || (funct3_s == 3'b001) || (funct3_s == 3'b010)) begin
          decoded_s.exe_fun  = ALU_ADD;
          decoded_s.op1_data = rs1_data;
          decoded_s.op2_data = imm_s_s;
        end else begin
          decoded_s.illegal = 1'b1;
        end
      end
      default: decoded_s.illegal = 1'b1;
    endcase
    decoded_s.wb_en = wb_s && (rd_s != 5'd0) && !decoded_s.illegal;
  end

  // Upstream ready: skid occupancy only (skid mode) or output-slot free (no skid); never during flush.
  always_comb begin
    if (flush) begin
      id_ready = 1'b0;
    end else if (ENABLE_SKID) begin
      id_ready = !skid_valid_q;
    end else begin
      id_ready = !out_valid_q || ex_ready;
    end
  end

  assign accept_s = id_valid && id_ready && !flush;

  // Output/skid register next state: flush wins, then skid drain, then new accept.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (ex_ready) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b1;
      end
    end else if (accept_s) begin
      if (!out_valid_q || ex_ready) begin
        out_d       = decoded_s;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = decoded_s;
        skid_valid_d = 1'b1;
      end
    end else if (ex_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output and skid registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign ex_valid     = out_valid_q;
  assign ex_exe_fun   = out_q.exe_fun;
  assign ex_op1_data  = out_q.op1_data;
  assign ex_op2_data  = out_q.op2_data;
  assign ex_is_branch = out_q.is_branch;
  assign ex_is_jump   = out_q.is_jump;
  assign ex_br_target = out_q.br_target;
  assign ex_wb_en     = out_q.wb_en;
  assign ex_rd_addr   = out_q.rd_addr;
  assign ex_pc        = out_q.pc;
  assign ex_illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed scoreboard bench for decode_stage: skid instance (a) and no-skid instance (b).
module tb_decode_stage;
  import decode_stage_pkg::*;

  typedef struct packed {
    logic [4:0]  fun;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        br;
    logic        jmp;
    logic [31:0] tgt;
    logic        wb;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic id_valid_a = 1'b0, id_valid_b = 1'b0;
  logic [31:0] id_inst = 32'd0, id_pc = 32'd0, rs1_data = 32'd0, rs2_data = 32'd0;
  logic flush = 1'b0, ex_ready = 1'b0;

  logic id_ready_a, id_ready_b, ex_valid_a, ex_valid_b;
  logic [4:0] rs1_addr_a, rs2_addr_a, rs1_addr_b, rs2_addr_b;
  logic [4:0] fun_a, fun_b, rd_a, rd_b;
  logic [31:0] op1_a, op2_a, tgt_a, pc_a, op1_b, op2_b, tgt_b, pc_b;
  logic br_a, jmp_a, wb_a, ill_a, br_b, jmp_b, wb_b, ill_b;
  exp_t obs_a, obs_b;

  assign obs_a = {fun_a, op1_a, op2_a, br_a, jmp_a, tgt_a, wb_a, rd_a, pc_a, ill_a};
  assign obs_b = {fun_b, op1_b, op2_b, br_b, jmp_b, tgt_b, wb_b, rd_b, pc_b, ill_b};

  decode_stage #(.ENABLE_SKID(1'b1)) u_dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid_a), .id_ready(id_ready_a),
    .id_inst(id_inst), .id_pc(id_pc), .rs1_addr(rs1_addr_a), .rs2_addr(rs2_addr_a),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .ex_valid(ex_valid_a), .ex_ready(ex_ready), .ex_exe_fun(fun_a),
    .ex_op1_data(op1_a), .ex_op2_data(op2_a), .ex_is_branch(br_a), .ex_is_jump(jmp_a),
    .ex_br_target(tgt_a), .ex_wb_en(wb_a), .ex_rd_addr(rd_a), .ex_pc(pc_a), .ex_illegal(ill_a)
  );

  decode_stage #(.ENABLE_SKID(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid_b), .id_ready(id_ready_b),
    .id_inst(id_inst), .id_pc(id_pc), .rs1_addr(rs1_addr_b), .rs2_addr(rs2_addr_b),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .ex_valid(ex_valid_b), .ex_ready(ex_ready), .ex_exe_fun(fun_b),
    .ex_op1_data(op1_b), .ex_op2_data(op2_b), .ex_is_branch(br_b), .ex_is_jump(jmp_b),
    .ex_br_target(tgt_b), .ex_wb_en(wb_b), .ex_rd_addr(rd_b), .ex_pc(pc_b), .ex_illegal(ill_b)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t pend, held_a, held_b, e;
  logic stall_a = 1'b0, stall_b = 1'b0, acc = 1'b0, sel = 1'b0;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] fun, input logic [31:0] op1, input logic [31:0] op2,
                              input logic br, input logic jmp, input logic [31:0] tgt, input logic wb,
                              input logic [4:0] rd, input logic [31:0] pc, input logic ill);
    return '{fun, op1, op2, br, jmp, tgt, wb, rd, pc, ill};
  endfunction

  function automatic exp_t addi_exp(input logic [31:0] r1, input logic [31:0] pc);
    return mk(ALU_ADD, r1, 32'd5, 1'b0, 1'b0, 32'd0, 1'b1, 5'd1, pc, 1'b0);
  endfunction

  // One cycle: compare deliveries, check holds/ready, record accepts, then advance.
  task automatic tick(input int exp_rdy);
    @(negedge clk);
    if (stall_a) begin
      chk("hold_valid_a", ex_valid_a, 1'b1);
      chk("hold_payload_a", obs_a, held_a);
    end
    if (stall_b) begin
      chk("hold_valid_b", ex_valid_b, 1'b1);
      chk("hold_payload_b", obs_b, held_b);
    end
    if (ex_valid_a && ex_ready) begin
      if (qa.size() == 0) chk("spurious_a", ex_valid_a, 1'b0);
      else begin e = qa.pop_front(); chk("deliver_a", obs_a, e); end
    end
    if (ex_valid_b && ex_ready) begin
      if (qb.size() == 0) chk("spurious_b", ex_valid_b, 1'b0);
      else begin e = qb.pop_front(); chk("deliver_b", obs_b, e); end
    end
    stall_a = ex_valid_a && !ex_ready && !flush;
    stall_b = ex_valid_b && !ex_ready && !flush;
    held_a = obs_a;
    held_b = obs_b;
    if (exp_rdy >= 0) chk(sel ? "id_ready_b" : "id_ready_a", sel ? id_ready_b : id_ready_a, exp_rdy[0]);
    if (id_valid_a && id_ready_a && !flush) begin qa.push_back(pend); acc = 1'b1; end
    if (id_valid_b && id_ready_b && !flush) begin qb.push_back(pend); acc = 1'b1; end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] r1,
                       input logic [31:0] r2, input exp_t ex);
    id_inst = inst; id_pc = pc; rs1_data = r1; rs2_data = r2; pend = ex; acc = 1'b0;
    if (sel) id_valid_b = 1'b1; else id_valid_a = 1'b1;
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] r1,
                      input logic [31:0] r2, input exp_t ex, input int exp_rdy);
    drive(inst, pc, r1, r2, ex);
    tick(exp_rdy);
    for (int n = 0; n < 20 && !acc; n++) tick(-1);
    if (!acc) chk("accept_timeout", acc, 1'b1);
  endtask

  task automatic idle(input int n, input int exp_rdy);
    id_valid_a = 1'b0; id_valid_b = 1'b0;
    for (int i = 0; i < n; i++) tick(exp_rdy);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst_ex_valid_a", ex_valid_a, 1'b0);
    chk("rst_id_ready_a", id_ready_a, 1'b1);
    chk("rst_fun_a", fun_a, ALU_X);
    chk("rst_payload_a", obs_a, '0);
    chk("rst_id_ready_b", id_ready_b, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    ex_ready = 1'b1;
    sel = 1'b0;

    // Decode table, back-to-back at full throughput.
    drive(32'h00510093, 32'h0, 32'd7, 32'h55, addi_exp(32'd7, 32'h0));
    #1;
    chk("rs1_addr", rs1_addr_a, 5'd2);
    chk("rs2_addr", rs2_addr_a, 5'd5);
    tick(1);
    send(32'hFE209EE3, 32'h100, 32'h11, 32'h22, mk(BR_BNE, 32'h11, 32'h22, 1'b1, 1'b0, 32'hFC, 1'b0, 5'd29, 32'h100, 1'b0), 1);
    send(32'h123452B7, 32'h104, 32'h33, 32'h44, mk(ALU_COPY1, 32'h12345000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 5'd5, 32'h104, 1'b0), 1);
    send(32'h00000000, 32'h108, 32'h33, 32'h44, mk(ALU_X, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h108, 1'b1), 1);
    send(32'h002081B3, 32'h10C, 32'd10, 32'd3, mk(ALU_ADD, 32'd10, 32'd3, 1'b0, 1'b0, 32'h0, 1'b1, 5'd3, 32'h10C, 1'b0), 1);
    send(32'h402081B3, 32'h110, 32'd10, 32'd3, mk(ALU_SUB, 32'd10, 32'd3, 1'b0, 1'b0, 32'h0, 1'b1, 5'd3, 32'h110, 1'b0), 1);
    send(32'h4030D213, 32'h114, 32'h80000000, 32'd0, mk(ALU_SRA, 32'h80000000, 32'd3, 1'b0, 1'b0, 32'h0, 1'b1, 5'd4, 32'h114, 1'b0), 1);
    send(32'h008000EF, 32'h200, 32'd0, 32'd0, mk(ALU_ADD, 32'h200, 32'd4, 1'b0, 1'b1, 32'h208, 1'b1, 5'd1, 32'h200, 1'b0), 1);
    send(32'h00008067, 32'h204, 32'h400, 32'd0, mk(ALU_JALR, 32'h400, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 5'd0, 32'h204, 1'b0), 1);
    send(32'h0020A423, 32'h208, 32'h1000, 32'hAB, mk(ALU_ADD, 32'h1000, 32'd8, 1'b0, 1'b0, 32'h0, 1'b0, 5'd8, 32'h208, 1'b0), 1);
    send(32'hFFC0A303, 32'h20C, 32'h1000, 32'hAB, mk(ALU_ADD, 32'h1000, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0, 1'b1, 5'd6, 32'h20C, 1'b0), 1);
    send(32'h00001397, 32'h300, 32'd0, 32'd0, mk(ALU_ADD, 32'h300, 32'h1000, 1'b0, 1'b0, 32'h0, 1'b1, 5'd7, 32'h300, 1'b0), 1);
    send(32'h202081B3, 32'h304, 32'd10, 32'd3, mk(ALU_X, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd3, 32'h304, 1'b1), 1);
    send(32'h0080006F, 32'hFFFFFFFC, 32'd0, 32'd0, mk(ALU_ADD, 32'hFFFFFFFC, 32'd4, 1'b0, 1'b1, 32'h4, 1'b0, 5'd0, 32'hFFFFFFFC, 1'b0), 1);
    idle(2, 1);

    // Backpressure on the skid instance: three instructions, ex_ready low for two data cycles.
    ex_ready = 1'b0;
    send(32'h00510093, 32'h400, 32'd1, 32'd0, addi_exp(32'd1, 32'h400), 1);
    send(32'h00510093, 32'h404, 32'd2, 32'd0, addi_exp(32'd2, 32'h404), 1);
    drive(32'h00510093, 32'h408, 32'd3, 32'd0, addi_exp(32'd3, 32'h408));
    tick(0);
    ex_ready = 1'b1;
    tick(0);
    tick(1);
    chk("bp_accept_a", acc, 1'b1);
    idle(3, 1);

    // Flush with skid full and a new instruction offered.
    ex_ready = 1'b0;
    send(32'h00510093, 32'h500, 32'd11, 32'd0, addi_exp(32'd11, 32'h500), 1);
    send(32'h00510093, 32'h504, 32'd12, 32'd0, addi_exp(32'd12, 32'h504), 1);
    drive(32'h00510093, 32'h508, 32'd13, 32'd0, addi_exp(32'd13, 32'h508));
    flush = 1'b1;
    tick(0);
    flush = 1'b0;
    id_valid_a = 1'b0;
    qa.delete();
    chk("flush_ex_valid_a", ex_valid_a, 1'b0);
    tick(1);
    ex_ready = 1'b1;
    idle(3, 1);
    send(32'h00510093, 32'h50C, 32'd14, 32'd0, addi_exp(32'd14, 32'h50C), 1);
    idle(2, 1);
    // Flush alone blocks upstream even with an empty pipe.
    drive(32'h00510093, 32'h510, 32'd15, 32'd0, addi_exp(32'd15, 32'h510));
    flush = 1'b1;
    tick(0);
    flush = 1'b0;
    id_valid_a = 1'b0;
    chk("flush_only_ex_valid_a", ex_valid_a, 1'b0);
    idle(2, 1);

    // Asynchronous reset with output and skid registers both full.
    ex_ready = 1'b0;
    send(32'h00510093, 32'h600, 32'd21, 32'd0, addi_exp(32'd21, 32'h600), 1);
    send(32'h00510093, 32'h604, 32'd22, 32'd0, addi_exp(32'd22, 32'h604), 1);
    id_valid_a = 1'b0;
    chk("pre_rst_ex_valid_a", ex_valid_a, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ex_valid_a", ex_valid_a, 1'b0);
    chk("mid_rst_id_ready_a", id_ready_a, 1'b1);
    chk("mid_rst_fun_a", fun_a, ALU_X);
    reset = 1'b0;
    qa.delete();
    stall_a = 1'b0;
    ex_ready = 1'b1;
    idle(3, 1);

    // No-skid instance: backpressure, throughput and flush.
    sel = 1'b1;
    ex_ready = 1'b0;
    send(32'h00510093, 32'h700, 32'd31, 32'd0, addi_exp(32'd31, 32'h700), 1);
    drive(32'h00510093, 32'h704, 32'd32, 32'd0, addi_exp(32'd32, 32'h704));
    tick(0);
    tick(0);
    ex_ready = 1'b1;
    tick(1);
    chk("bp_accept_b", acc, 1'b1);
    send(32'h00510093, 32'h708, 32'd33, 32'd0, addi_exp(32'd33, 32'h708), 1);
    send(32'h00510093, 32'h70C, 32'd34, 32'd0, addi_exp(32'd34, 32'h70C), 1);
    idle(2, 1);
    drive(32'h00510093, 32'h710, 32'd35, 32'd0, addi_exp(32'd35, 32'h710));
    flush = 1'b1;
    tick(0);
    flush = 1'b0;
    id_valid_b = 1'b0;
    chk("flush_ex_valid_b", ex_valid_b, 1'b0);
    idle(3, 1);

    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
